mac_result_serializer: RTL and testbench

MAC_RESULT_SERIALIZER -- requirements
Module: mac_result_serializer

---
 rtl/mac_result_serializer.sv | 127 ++++++++++++
 tb/tb_mac_result_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_serializer.sv
// Frames MAC accumulator results as byte streams: header {4'hA, seq} then the data bytes, MSB first.
// Has a one-entry pending buffer so a back-to-back result can chain frames with no idle cycle.
module mac_result_serializer #(
  parameter int WIDTH  = 41,
  parameter int NBYTES = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int SW   = NBYTES * 8;
  localparam int IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LAST = NBYTES - 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic [3:0]      seq;
  logic [SW-1:0]   shift;
  logic [SW-1:0]   pend;
  logic            pend_full;
  logic [SW-1:0]   in_ext;
  logic [7:0]      out_q;
  logic            valid_q;
  logic            last_q;
  logic            in_fire;
  logic            out_fire;
  logic            idx_last;

  assign in_ext    = SW'(in_data);
  assign in_ready  = ena && !pend_full;
  assign out_valid = ena && valid_q;
  assign out_data  = out_q;
  assign out_last  = last_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign idx_nxt   = idx + 1'b1;
  assign idx_last  = (idx == IW'(LAST));

  // The next byte is always taken from the top of shift, which moves up one byte per transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      seq       <= '0;
      shift     <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      out_q     <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            shift   <= in_ext;
            state   <= HDR;
            out_q   <= {4'hA, seq};
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        HDR: begin
          if (in_fire) begin
            pend      <= in_ext;
            pend_full <= 1'b1;
          end
          if (out_fire) begin
            state  <= DATA;
            idx    <= '0;
            out_q  <= shift[SW-1 -: 8];
            shift  <= shift << 8;
            last_q <= (NBYTES == 1);
          end
        end
        DATA: begin
          if (out_fire && idx_last) begin
            seq    <= seq + 4'd1;
            last_q <= 1'b0;
            idx    <= '0;
            // Chain straight into the next header when a result is waiting.
            if (pend_full) begin
              shift     <= pend;
              pend_full <= 1'b0;
              state     <= HDR;
              out_q     <= {4'hA, seq + 4'd1};
            end else if (in_fire) begin
              shift <= in_ext;
              state <= HDR;
              out_q <= {4'hA, seq + 4'd1};
            end else begin
              state   <= IDLE;
              valid_q <= 1'b0;
            end
          end else begin
            if (in_fire) begin
              pend      <= in_ext;
              pend_full <= 1'b1;
            end
            if (out_fire) begin
              idx    <= idx_nxt;
              out_q  <= shift[SW-1 -: 8];
              shift  <= shift << 8;
              last_q <= (idx_nxt == IW'(LAST));
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed bench for mac_result_serializer: single frames, chained frames, stalls,
// sequence wrap, mid-frame reset and enable freeze.
module tb_mac_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        in_valid = 1'b0;
  logic [40:0] in_data = '0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;

  logic        stall_mode = 1'b0;
  logic        ready_level = 1'b1;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [7:0] byte_q[$];
  bit         last_bq[$];
  int         stamp_q[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  logic [7:0] frame1 [7] = '{8'hA0, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
  logic [7:0] frame2 [7] = '{8'hA1, 8'h00, 8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76};
  logic [7:0] frame2r[7] = '{8'hA0, 8'h00, 8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76};

  localparam logic [40:0] D1 = 41'h1_2345_6789_AB;
  localparam logic [40:0] D2 = 41'h0_FEDC_BA98_76;

  mac_result_serializer #(.WIDTH(41), .NBYTES(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = stall_mode ? 1'($urandom_range(0, 1)) : ready_level;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Records every transfer one half-cycle ahead of its edge; also checks hold during stalls.
  always @(negedge clk) begin
    if (prev_stall && ena && rst_n) begin
      check("hold_data", out_data, prev_data);
      check("hold_valid", out_valid, 1'b1);
      check("hold_last", out_last, prev_last);
    end
    prev_stall <= out_valid && !out_ready;
    prev_data  <= out_data;
    prev_last  <= out_last;
    if (out_valid && out_ready) begin
      byte_q.push_back(out_data);
      last_bq.push_back(out_last);
      stamp_q.push_back(cyc);
    end
  end

  task automatic clear_q();
    byte_q.delete();
    last_bq.delete();
    stamp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_q();
  endtask

  task automatic push(input logic [40:0] d);
    int c = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("push_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c = 0;
    while (byte_q.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, byte_q.size(), n);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] exp [7]);
    for (int i = 0; i < 7; i++) begin
      if (base + i < byte_q.size()) begin
        check($sformatf("%s_byte%0d", tag, i), byte_q[base+i], exp[i]);
        check($sformatf("%s_last%0d", tag, i), last_bq[base+i], (i == 6));
      end else begin
        check($sformatf("%s_missing%0d", tag, i), byte_q.size(), base + i + 1);
      end
    end
  endtask

  task automatic check_no_gap(input string tag, input int n);
    for (int i = 1; i < n && i < stamp_q.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), stamp_q[i] - stamp_q[0], i);
  endtask

  initial begin
    // reset state and in_ready tracking ena during reset
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    do_reset();

    // single frame, no stalls
    check("t1_idle_valid", out_valid, 1'b0);
    push(D1);
    check("t1_valid_after_capture", out_valid, 1'b1);
    check("t1_first_hdr", out_data, 8'hA0);
    wait_bytes("t1_count", 7, 50);
    check_frame("t1", 0, frame1);
    check_no_gap("t1", 7);
    repeat (3) @(posedge clk);
    #1;
    check("t1_no_extra", byte_q.size(), 7);

    // back-to-back results chained through the pending buffer
    do_reset();
    push(D1);
    push(D2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t2_in_ready_low%0d", i), in_ready, 1'b0);
    end
    @(negedge clk);
    check("t2_in_ready_back", in_ready, 1'b1);
    wait_bytes("t2_count", 14, 50);
    check_frame("t2a", 0, frame1);
    check_frame("t2b", 7, frame2);
    check_no_gap("t2", 14);

    // same traffic with random downstream stalls
    do_reset();
    stall_mode = 1'b1;
    push(D1);
    push(D2);
    wait_bytes("t3_count", 14, 600);
    stall_mode = 1'b0;
    check_frame("t3a", 0, frame1);
    check_frame("t3b", 7, frame2);
    repeat (3) @(posedge clk);
    #1;

    // 17 frames to see the sequence number wrap
    do_reset();
    for (int k = 0; k < 17; k++) push(41'(k));
    wait_bytes("t4_count", 17 * 7, 400);
    for (int k = 0; k < 17; k++) begin
      if (7 * k + 6 < byte_q.size()) begin
        check($sformatf("t4_hdr%0d", k), byte_q[7*k], {4'hA, 4'(k)});
        check($sformatf("t4_lsb%0d", k), byte_q[7*k+6], 8'(k));
        check($sformatf("t4_last%0d", k), last_bq[7*k+6], 1'b1);
      end
    end
    check_no_gap("t4", 17 * 7);

    // reset in the middle of a data phase
    do_reset();
    push(D1);
    push(D2);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid_in_reset", out_valid, 1'b0);
    check("t5_data_in_reset", out_data, 8'h00);
    check("t5_in_ready_in_reset", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_q();
    check("t5_idle_after_reset", out_valid, 1'b0);
    push(D2);
    wait_bytes("t5_count", 7, 50);
    check_frame("t5", 0, frame2r);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_extra", byte_q.size(), 7);

    // enable low for five cycles mid-frame
    do_reset();
    push(D1);
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t6_valid_frozen%0d", i), out_valid, 1'b0);
      check($sformatf("t6_ready_frozen%0d", i), in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    ena = 1'b1;
    wait_bytes("t6_count", 7, 50);
    check_frame("t6", 0, frame1);
    if (stamp_q.size() >= 4) check("t6_pause_len", stamp_q[3] - stamp_q[2], 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
